// File: rtl/channel_pkg.sv
// Shared types and constants for the channel models: LFSR seed/taps, channel and burst state encodings.
package channel_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps at bits 15,13,12,10 realise x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [16:0] PROB_ONE  = 17'd65536;

  typedef enum logic {
    BAD  = 1'b0,
    GOOD = 1'b1
  } chan_state_e;

  typedef enum logic {
    NO_BURST = 1'b0,
    IN_BURST = 1'b1
  } burst_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/error_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR used as the uniform source for error decisions.
// Steps only when advance is high; the seed is non-zero so the register never reaches 0.
module error_lfsr16
  import channel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/burst_error_injector.sv
// State-dependent binary symmetric channel with a one-deep valid/ready output register and error statistics.
// Define BURST_STATS_EN to add burst_count/max_burst outputs and the burst-tracking FSM.
module burst_error_injector
  import channel_pkg::*;
#(
  parameter int BER_GOOD = 16,
  parameter int BER_BAD  = 6554,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             channel_state,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_err,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
`ifdef BURST_STATS_EN
  ,
  output logic [CNT_W-1:0] burst_count,
  output logic [15:0]      max_burst
`endif
);

  localparam logic [16:0]      THR_GOOD = (BER_GOOD >= 65536) ? PROB_ONE : 17'(BER_GOOD);
  localparam logic [16:0]      THR_BAD  = (BER_BAD  >= 65536) ? PROB_ONE : 17'(BER_BAD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [15:0] lfsr;
  logic        accept;
  logic        err;
  logic [16:0] thr;
  chan_state_e cs;

  assign cs       = chan_state_e'(channel_state);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign thr      = (cs == GOOD) ? THR_GOOD : THR_BAD;
  // The LFSR never holds 0, so a threshold of 1 can never produce a flip.
  assign err      = ({1'b0, lfsr} < thr);

  error_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= in_bit ^ err;
      out_err   <= err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear beats are deliberately not counted, even though they are forwarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (stats_clr) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_ONE;
      if (err && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
    end
  end

`ifdef BURST_STATS_EN
  burst_state_e     bstate_q, bstate_d;
  logic [15:0]      run_q, run_d;
  logic [CNT_W-1:0] burst_d;

  always_comb begin
    bstate_d = bstate_q;
    run_d    = run_q;
    burst_d  = burst_count;
    if (accept) begin
      case (bstate_q)
        NO_BURST: begin
          if (err) begin
            bstate_d = IN_BURST;
            run_d    = 16'd1;
            if (burst_count != CNT_MAX) burst_d = burst_count + CNT_ONE;
          end
        end
        IN_BURST: begin
          if (!err) begin
            bstate_d = NO_BURST;
          end else if (run_q != 16'hFFFF) begin
            run_d = run_q + 16'd1;
          end
        end
        default: bstate_d = NO_BURST;
      endcase
    end
  end

  // max_burst follows the registered run length, so it settles one cycle after a burst grows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bstate_q    <= NO_BURST;
      run_q       <= '0;
      burst_count <= '0;
      max_burst   <= '0;
    end else if (stats_clr) begin
      bstate_q    <= NO_BURST;
      run_q       <= '0;
      burst_count <= '0;
      max_burst   <= '0;
    end else begin
      bstate_q    <= bstate_d;
      run_q       <= run_d;
      burst_count <= burst_d;
      if (run_q > max_burst) max_burst <= run_q;
    end
  end
`endif

endmodule

// File: doc/burst_error_injector.md
Name: burst_error_injector

Overview:
- Channel stage directly downstream of the Gilbert state generator; consumes its `channel_state` (1 = Good, 0 = Bad).
- Passes a serial TX bitstream through a state-dependent binary symmetric channel: each accepted bit is flipped with probability BER_GOOD/65536 or BER_BAD/65536.
- Drives the corrupted stream to the receiver/decoder through a one-deep valid/ready register stage.
- Keeps error statistics.

Parameters:
- BER_GOOD, 16, flip probability in Good state in units of 1/65536; range 0..65536.
- BER_BAD, 6554, flip probability in Bad state in units of 1/65536 (about 10%); range 0..65536.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- channel_state  in  1  Gilbert state; 1 = Good, 0 = Bad; sampled on accept.
- in_valid  in  1  upstream bit valid.
- in_ready  out  1  stage can accept.
- in_bit  in  1  transmitted bit.
- out_valid  out  1  corrupted bit valid.
- out_ready  in  1  downstream accepts.
- out_bit  out  1  received (possibly flipped) bit.
- out_err  out  1  out_bit was flipped; qualified by out_valid.
- stats_clr  in  1  synchronous clear of the counters.
- bit_count  out  CNT_W  accepted bits since reset/clear.
- err_count  out  CNT_W  flipped bits since reset/clear.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_bit=0, out_err=0, bit_count=0, err_count=0.
  - LFSR loaded with seed 16'hACE1.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept:
  - thr = channel_state ? BER_GOOD : BER_BAD, zero-extended to 17 bits.
  - err = ({1'b0,lfsr} < thr).
  - out_bit <= in_bit ^ err; out_err <= err; out_valid <= 1.
  - LFSR advances one step.
  - Latency is 1 cycle: accepted in cycle N, visible on the output in cycle N+1.
- If out_valid && out_ready && !accept, out_valid <= 0 (out_bit and out_err hold).
- Backpressure: while out_valid && !out_ready, out_bit and out_err are stable and in_ready=0.
- Accept and drain in the same cycle sustains 1 bit/clk.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, feedback = l[15]^l[13]^l[12]^l[10], shift left.
  - Advances only on accept, so the error pattern is a deterministic function of the accepted-bit index and channel_state.
  - Never holds 0.
- Boundaries:
  - thr=0 never flips.
  - thr=65536 always flips.
  - The LFSR never reaches 0, so thr=1 also never flips.
- Counters:
  - bit_count increments on every accept.
  - err_count increments on accept with err=1.
  - Both saturate at all-ones and do not wrap.
- stats_clr wins over a same-cycle increment: counters become 0 and that beat is not counted. The beat is still forwarded, and the LFSR still advances.
- channel_state is used only at accept; changes while stalled have no effect on the held output.
- Reset mid-stream drops the held bit (out_valid=0) and restarts the LFSR sequence from the seed.

Optional Feature:
- Macro BURST_STATS_EN.
- Defined: adds outputs `burst_count` [CNT_W] and `max_burst` [15:0], driven by a 2-state FSM (NO_BURST, IN_BURST) stepped only on accept.
  - NO_BURST→IN_BURST on err=1: burst_count++ and run=1.
  - IN_BURST stays while err=1: run++, saturating at 16'hFFFF.
  - IN_BURST→NO_BURST on err=0.
  - max_burst <= max(max_burst, run) is updated every cycle.
  - Reset and stats_clr zero run, burst_count and max_burst and force NO_BURST.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Package `channel_pkg` holds:
  - LFSR_SEED = 16'hACE1 and LFSR_TAPS mask.
  - typedef chan_state_e {BAD=1'b0, GOOD=1'b1}, matching the channel_state encoding.
  - typedef burst_state_e {NO_BURST, IN_BURST}.
  - PROB_ONE = 17'd65536.
- Sub-module `error_lfsr16` (clk, reset, advance, value[15:0]) is reused by other channel models.

Test Plan:
- BER_GOOD=0, channel_state=1, 1000 random bits, out_ready=1: out_bit==in_bit for every bit; err_count=0, bit_count=1000; throughput 1 bit/clk.
- BER_BAD=65536, channel_state=0, send 1,0,1,1: outputs 0,1,0,0, each 1 cycle after accept; out_err=1 every beat; err_count=4.
- Default parameters, channel_state held 0, 65535 bits: err_count equals the golden-model count over one full LFSR period (about 6553); compare bit-exactly against the reference LFSR model.
- out_ready=0 for 5 cycles with a bit held: in_ready=0 and out_bit/out_err stable; LFSR and bit_count do not advance; releasing out_ready delivers the bit and the next accept proceeds.
- stats_clr in the same cycle as an erroneous accept with err_count=7: err_count=0 next cycle, the bit is still delivered flipped; with BURST_STATS_EN, run a 3-error burst then 1 good bit: burst_count=1, max_burst=3.
- Assert reset while out_valid=1: out_valid=0 immediately (async); after release, the first 16 error decisions repeat the post-reset sequence exactly.
